// File: rtl/layer_mac_sequencer_pkg.sv
// layer_pkg: shared state encoding and accumulator sizing for the layer MAC sequencer
package layer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} layer_state_t;
  function automatic int acc_width(input int w, input int x, input int n);
    return w + x + $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/layer_mac_lane.sv
// layer_mac_lane: signed weight x unsigned activation multiply-accumulate with clear and enable
module layer_mac_lane #(
  parameter int w_size = 8,
  parameter int x_size = 8,
  parameter int a_size = 19
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic [w_size-1:0]        w,
  input  logic [x_size-1:0]        x,
  output logic signed [a_size-1:0] acc
);
  logic signed [w_size+x_size:0] prod;
  logic signed [a_size-1:0] acc_q, acc_d;
  assign prod = $signed(w) * $signed({1'b0, x});
  always_comb acc_d = clr ? '0 : en ? acc_q + a_size'(prod) : acc_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/layer_mac_sequencer.sv
// layer_mac_sequencer: walks one-hot ROM rows and accumulates one fully connected layer.
// Define LAYER_RELU_EN to clamp negative results to zero on the output path.
module layer_mac_sequencer
  import layer_pkg::*;
#(
  parameter int w_size      = 8,
  parameter int x_size      = 8,
  parameter int neurons_in  = 4,
  parameter int neurons_out = 4,
  parameter int a_size      = acc_width(w_size, x_size, neurons_in)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [neurons_in*x_size-1:0]  x_in,
  output logic                          busy,
  output logic [neurons_in-1:0]         rom_addr,
  input  logic [neurons_out*w_size-1:0] rom_data,
  output logic [neurons_out*a_size-1:0] y_out,
  output logic                          out_valid,
  input  logic                          out_ready
);
  localparam int kw = neurons_in > 1 ? $clog2(neurons_in) : 1;
  logic [1:0] rst_sync_q, rst_sync_d;
  logic rst_i_n;
  layer_state_t state_q, state_d;
  logic [kw-1:0] k_q, k_d;
  logic [neurons_in*x_size-1:0] x_q, x_d;
  logic clr, en;
  logic [x_size-1:0] x_k;
  logic signed [a_size-1:0] acc [neurons_out];
  // reset asserts immediately but releases two edges later, in step with clk
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync_q <= '0;
    else rst_sync_q <= rst_sync_d;
  assign rst_i_n = rst_sync_q[1];
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    clr     = 1'b0;
    en      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        k_d     = '0;
        x_d     = x_in;
        clr     = 1'b1;
      end
      RUN: begin
        en      = 1'b1;
        state_d = (k_q == kw'(neurons_in - 1)) ? DONE : RUN;
        k_d     = (k_q == kw'(neurons_in - 1)) ? k_q : k_q + 1'b1;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_i_n)
    if (!rst_i_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
    end
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign rom_addr  = (state_q == RUN) ? neurons_in'(1) << k_q : '0;
  assign x_k       = x_q[k_q*x_size +: x_size];
  for (genvar j = 0; j < neurons_out; j++) begin : g_lane
    layer_mac_lane #(.w_size(w_size), .x_size(x_size), .a_size(a_size)) u_lane (
      .clk(clk),
      .rst_n(rst_i_n),
      .clr(clr),
      .en(en),
      .w(rom_data[j*w_size +: w_size]),
      .x(x_k),
      .acc(acc[j])
    );
`ifdef LAYER_RELU_EN
    assign y_out[j*a_size +: a_size] = acc[j][a_size-1] ? '0 : acc[j];
`else
    assign y_out[j*a_size +: a_size] = acc[j];
`endif
  end
endmodule

// File: tb/tb_layer_mac_sequencer.sv
// tb_layer_mac_sequencer: scoreboard bench for layer_mac_sequencer with a behavioural one-hot ROM
module tb_layer_mac_sequencer;
  localparam int NI = 4, NO = 4, W = 8, X = 8, A = 19, YW = NO*A;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [NI*X-1:0] x_in = '0;
  logic busy, out_valid;
  logic [NI-1:0] rom_addr;
  logic [NO*W-1:0] rom_data;
  logic [YW-1:0] y_out;
  logic [NO*W-1:0] rom [NI];
  logic [YW-1:0] sb [$];
  int total = 0, bad = 0;

  layer_mac_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .busy(busy),
    .rom_addr(rom_addr), .rom_data(rom_data), .y_out(y_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    rom_data = '0;
    for (int k = 0; k < NI; k++) if (rom_addr[k]) rom_data = rom_data | rom[k];
  end

  task automatic chk(input string tag, input logic [YW-1:0] got, input logic [YW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [YW-1:0] model(input logic [NI*X-1:0] xv);
    logic [YW-1:0] r;
    r = '0;
    for (int j = 0; j < NO; j++) begin
      int s;
      s = 0;
      for (int k = 0; k < NI; k++)
        s += int'($signed(rom[k][j*W +: W])) * int'(xv[k*X +: X]);
`ifdef LAYER_RELU_EN
      if (s < 0) s = 0;
`endif
      r[j*A +: A] = s[A-1:0];
    end
    return r;
  endfunction

  task automatic run(input logic [NI*X-1:0] xv, input int hold, input bit start_with_ready);
    logic [YW-1:0] held;
    logic [15:0] alog;
    int n;
    sb.push_back(model(xv));
    x_in = xv;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    alog = '0;
    while (!out_valid && n < 20) begin
      if (n <= NI) alog[(n-1)*4 +: 4] = rom_addr;
      x_in = {$urandom, $urandom};
      tick();
      n++;
    end
    chk("latency", YW'(n), YW'(5));
    chk("addr_seq", YW'(alog), YW'(16'h8421));
    held = y_out;
    for (int i = 0; i < hold; i++) begin
      start = (i == 3);
      tick();
      start = 1'b0;
      chk("hold_valid", YW'(out_valid), YW'(1));
      chk("hold_y", y_out, held);
    end
    if (hold > 0) chk("busy_bp", YW'(busy), YW'(1));
    out_ready = 1'b1;
    start = start_with_ready;
    if (sb.size() == 0) chk("sb_empty", YW'(0), YW'(1));
    else chk("y_out", y_out, sb.pop_front());
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    chk("valid_drop", YW'(out_valid), YW'(0));
    chk("idle_busy", YW'(busy), YW'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NI; k++) rom[k] = (NO*W)'(1) << (k*W);
    #12;
    chk("rst_busy", YW'(busy), YW'(0));
    chk("rst_addr", YW'(rom_addr), YW'(0));
    chk("rst_valid", YW'(out_valid), YW'(0));
    chk("rst_y", y_out, YW'(0));
    rst_n = 1'b1;
    repeat (3) tick();
    // reset asserted two cycles into a run
    x_in = 32'h09080706;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", YW'(busy), YW'(0));
    chk("mid_rst_addr", YW'(rom_addr), YW'(0));
    chk("mid_rst_valid", YW'(out_valid), YW'(0));
    chk("mid_rst_y", y_out, YW'(0));
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    // identity ROM: y[j] = x[j]
    run(32'h04030201, 0, 1'b0);
    chk("ident_y0", YW'(y_out[A-1:0]), YW'(1));
    chk("ident_y3", YW'(y_out[3*A +: A]), YW'(4));
    // most negative weights against full-scale activations
    for (int k = 0; k < NI; k++) rom[k] = 32'h80808080;
    run(32'hFFFFFFFF, 0, 1'b0);
    // backpressure with a stray start pulse
    for (int k = 0; k < NI; k++) rom[k] = $urandom;
    run($urandom, 10, 1'b0);
    // start coincident with accept is dropped
    run($urandom, 0, 1'b1);
    tick();
    chk("no_restart", YW'(busy), YW'(0));
    run($urandom, 0, 1'b0);
    // back-to-back runs, x_in scrambled during each
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NI; k++) rom[k] = $urandom;
      run($urandom, r, 1'b0);
    end
    chk("sb_drained", YW'(sb.size()), YW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
